multi_digit_counter: RTL

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

---
 rtl/multi_digit_counter.sv | 79 +++++++
 1 files changed

// File: rtl/multi_digit_counter.sv
// Cascaded modulo-(MAX+1) digit counter with up/down stepping, clamped parallel load
// and a registered full-wrap pulse. All digits advance together on a single clock edge.
module multi_digit_counter #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4,
  parameter int MAX    = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      load,
  input  logic [DIGITS*WIDTH-1:0]   load_value,
  output logic [DIGITS*WIDTH-1:0]   count,
  output logic                      wrap,
  output logic                      at_term
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  logic [DIGITS*WIDTH-1:0] r_count;
  logic                    r_wrap;
  logic [DIGITS*WIDTH-1:0] w_step;
  logic [DIGITS*WIDTH-1:0] w_clamp;
  logic                    w_carry;
  logic                    w_all_max;
  logic                    w_all_zero;
  logic [WIDTH-1:0]        w_d;
  logic [WIDTH-1:0]        w_l;

  // Carry is evaluated across all digits in one pass so every digit moves on the same edge.
  // Out-of-range digits count as MAX on the way up (>=), so they roll to 0 and carry.
  always_comb begin
    w_step     = r_count;
    w_clamp    = '0;
    w_carry    = 1'b1;
    w_all_max  = 1'b1;
    w_all_zero = 1'b1;
    w_d        = '0;
    w_l        = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_d = r_count[i*WIDTH +: WIDTH];
      w_l = load_value[i*WIDTH +: WIDTH];
      w_clamp[i*WIDTH +: WIDTH] = (w_l > MAX_W) ? MAX_W : w_l;
      w_all_max  = w_all_max  & (w_d == MAX_W);
      w_all_zero = w_all_zero & (w_d == '0);
      if (up_down) begin
        if (w_carry)
          w_step[i*WIDTH +: WIDTH] = (w_d >= MAX_W) ? '0 : w_d + WIDTH'(1);
        w_carry = w_carry & (w_d >= MAX_W);
      end else begin
        if (w_carry)
          w_step[i*WIDTH +: WIDTH] = (w_d == '0) ? MAX_W : w_d - WIDTH'(1);
        w_carry = w_carry & (w_d == '0);
      end
    end
  end

  assign at_term = up_down ? w_all_max : w_all_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_clamp;
      r_wrap  <= 1'b0;
    end else if (enable) begin
      r_count <= w_step;
      r_wrap  <= at_term;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule
